// File: rtl/arm_mc_controller.sv
// arm_mc_controller
//   Multicycle control unit for the ARM subset core. Decodes the instruction
//   register, steps each instruction through the main FSM and holds the NZCV
//   flags. Architectural writes are gated by the condition field, evaluated
//   over the stored flags. Memory states wait on a ready handshake.
//
//   Optional feature macro: ARM_MC_MUL_EN
//     When defined, MUL is decoded and runs for MUL_LAT cycles in EXECMUL.
//     When undefined, the MUL pattern takes the EXECUTER path with no register
//     write and no flag update. The EXECMUL state and its counter are not built.
//
// Parameters
//   MUL_LAT    cycles spent in EXECMUL (1..15)
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   Instr      instruction register contents
//   ALUFlags   {N,Z,C,V} from the ALU this cycle
//   MemReady   memory completes the current access this cycle
//   PCWrite    PC load enable
//   AdrSrc     memory address select: 0 PC, 1 ALUOut
//   MemWrite   data memory write strobe
//   IRWrite    instruction register load
//   RegWrite   register file write
//   ResultSrc  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    0 A register, 1 PC
//   ALUSrcB    00 WriteData, 01 ExtImm, 10 constant 4
//   ImmSrc     Instr[27:26]
//   RegSrc     bit0 read R15, bit1 read Rd as source 2
//   ALUControl 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL
//   State      current FSM state (debug)

module arm_mc_controller #(
   parameter int unsigned MUL_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [2:0]  ALUControl,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecuteR = 4'd6,
      StExecuteI = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9
`ifdef ARM_MC_MUL_EN
      , StExecMul = 4'd10
`endif
   } state_e;

   typedef enum logic [1:0] {
      FlNone,
      FlArith,
      FlLogic
   } flag_kind_e;

   state_e     state_q, state_d;
   logic [3:0] flags_q, flags_d;

   // Instruction fields
   logic [3:0] cond;
   logic [1:0] op;
   logic       funct_i;
   logic [3:0] cmd;
   logic       funct_s;
   logic       is_mul_pat;

   assign cond       = Instr[31:28];
   assign op         = Instr[27:26];
   assign funct_i    = Instr[25];
   assign cmd        = Instr[24:21];
   assign funct_s    = Instr[20];   // also the L bit for memory ops
   assign is_mul_pat = (op == 2'b00) && (Instr[7:4] == 4'b1001);

   logic unused_instr;
   assign unused_instr = ^{Instr[19:8], Instr[3:0]};

   assign ImmSrc = op;
   assign State  = state_q;

   // Condition evaluation over the stored flags
   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_ex;

   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      unique case (cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         4'b1111: cond_ex = 1'b0;
      endcase
   end

   // Data-processing decode
   logic [2:0] dp_alu;
   logic       dp_writes;
   flag_kind_e dp_kind;

   always_comb begin
      dp_alu    = 3'b000;
      dp_writes = 1'b0;
      dp_kind   = FlNone;
      case (cmd)
         4'b0100: begin dp_alu = 3'b000; dp_writes = 1'b1; dp_kind = FlArith; end
         4'b0010: begin dp_alu = 3'b001; dp_writes = 1'b1; dp_kind = FlArith; end
         4'b0000: begin dp_alu = 3'b010; dp_writes = 1'b1; dp_kind = FlLogic; end
         4'b1100: begin dp_alu = 3'b011; dp_writes = 1'b1; dp_kind = FlLogic; end
         4'b1010: begin dp_alu = 3'b001; dp_writes = 1'b0; dp_kind = FlArith; end
         default: begin dp_alu = 3'b000; dp_writes = 1'b0; dp_kind = FlNone;  end
      endcase
      if (is_mul_pat) begin
`ifdef ARM_MC_MUL_EN
         dp_alu    = 3'b100;
         dp_writes = 1'b1;
         dp_kind   = FlLogic;
`else
         // Without the multiplier the pattern is a harmless no-op
         dp_writes = 1'b0;
         dp_kind   = FlNone;
`endif
      end
   end

`ifdef ARM_MC_MUL_EN
   localparam logic [3:0] MulLoad = 4'(MUL_LAT - 1);
   logic [3:0] mul_cnt_q, mul_cnt_d;
`else
   logic [31:0] unused_mul_lat;
   assign unused_mul_lat = MUL_LAT;
`endif

   // Next state and outputs
   logic flag_upd;

   always_comb begin
      state_d    = state_q;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      RegSrc     = 2'b00;
      ALUControl = 3'b000;
      flag_upd   = 1'b0;
`ifdef ARM_MC_MUL_EN
      mul_cnt_d  = mul_cnt_q;
`endif

      unique case (state_q)
         StFetch: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
            if (MemReady) state_d = StDecode;
         end
         StDecode: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            RegSrc[0] = (op == 2'b10);
            RegSrc[1] = (op == 2'b01) & ~funct_s;
            case (op)
               2'b01:   state_d = StMemAdr;
               2'b10:   state_d = StBranch;
               2'b11:   state_d = StFetch;
               default: begin
`ifdef ARM_MC_MUL_EN
                  if (is_mul_pat) begin
                     state_d   = StExecMul;
                     mul_cnt_d = MulLoad;
                  end else begin
                     state_d = funct_i ? StExecuteI : StExecuteR;
                  end
`else
                  state_d = (funct_i && !is_mul_pat) ? StExecuteI : StExecuteR;
`endif
               end
            endcase
         end
         StMemAdr: begin
            ALUSrcB   = 2'b01;
            RegSrc[1] = ~funct_s;
            state_d   = funct_s ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            AdrSrc = 1'b1;
            if (MemReady) state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc = 2'b01;
            RegWrite  = cond_ex;
            state_d   = StFetch;
         end
         StMemWrite: begin
            AdrSrc    = 1'b1;
            RegSrc[1] = 1'b1;
            MemWrite  = cond_ex;
            if (MemReady) state_d = StFetch;
         end
         StExecuteR: begin
            ALUSrcB    = 2'b00;
            ALUControl = dp_alu;
            flag_upd   = 1'b1;
            state_d    = StAluWb;
         end
         StExecuteI: begin
            ALUSrcB    = 2'b01;
            ALUControl = dp_alu;
            flag_upd   = 1'b1;
            state_d    = StAluWb;
         end
         StAluWb: begin
            ResultSrc = 2'b00;
            RegWrite  = cond_ex & dp_writes;
            state_d   = StFetch;
         end
         StBranch: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            RegSrc[0] = 1'b1;
            PCWrite   = cond_ex;
            state_d   = StFetch;
         end
`ifdef ARM_MC_MUL_EN
         StExecMul: begin
            ALUControl = 3'b100;
            if (mul_cnt_q == 4'd0) begin
               flag_upd = 1'b1;
               state_d  = StAluWb;
            end else begin
               mul_cnt_d = mul_cnt_q - 4'd1;
            end
         end
`endif
         default: state_d = StFetch;
      endcase

      // Strobes stay quiet while reset is held, even before the clock edge
      if (!reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end

   // Flag register: logical ops and MUL keep C and V
   always_comb begin
      flags_d = flags_q;
      if (flag_upd && funct_s && cond_ex) begin
         case (dp_kind)
            FlArith: flags_d      = ALUFlags;
            FlLogic: flags_d[3:2] = ALUFlags[3:2];
            default: flags_d      = flags_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

`ifdef ARM_MC_MUL_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_cnt_q <= 4'd0;
      end else begin
         mul_cnt_q <= mul_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_arm_mc_controller.sv
module tb_arm_mc_controller;

   localparam int unsigned MulLat = 3;

   logic        clk;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
   logic [2:0]  ALUControl;
   logic [3:0]  State;

   arm_mc_controller #(.MUL_LAT(MulLat)) dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .ALUControl (ALUControl),
      .State      (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [3:0] mflags;   // reference NZCV

   typedef struct {
      logic [3:0] st;
      logic       mr;
      logic [3:0] af;
      logic [3:0] wr;     // {PCWrite, IRWrite, MemWrite, RegWrite}
      logic [2:0] aluc;
      logic       ck_alu;
   } cyc_t;

   cyc_t seq[$];

   // ---------------- reference model ----------------
   function automatic logic cond_holds(input logic [3:0] cd, input logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cd[3:1])
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (cd == 4'b1111) return 1'b0;
      return cd[0] ? !base : base;
   endfunction

   function automatic cyc_t mk(input logic [3:0] st, input logic mr, input logic [3:0] af,
                               input logic [3:0] wr, input logic [2:0] aluc, input logic ck);
      cyc_t c;
      c.st = st; c.mr = mr; c.af = af; c.wr = wr; c.aluc = aluc; c.ck_alu = ck;
      return c;
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction; updates mflags.
   task automatic build_seq(input logic [31:0] ins, input int fw, input int mw);
      logic       ce, ce2, writes, is_mul;
      logic [2:0] aluc;
      logic [1:0] kind;   // 0 none, 1 all four flags, 2 N and Z only
      logic [3:0] af, st;
      ce = cond_holds(ins[31:28], mflags);
      for (int i = 0; i < fw; i++) seq.push_back(mk(4'd0, 1'b0, 4'($urandom), 4'b0000, 3'd0, 1'b0));
      seq.push_back(mk(4'd0, 1'b1, 4'($urandom), 4'b1100, 3'd0, 1'b0));
      seq.push_back(mk(4'd1, 1'($urandom), 4'($urandom), 4'b0000, 3'd0, 1'b0));
      case (ins[27:26])
         2'b01: begin
            seq.push_back(mk(4'd2, 1'($urandom), 4'($urandom), 4'b0000, 3'd0, 1'b0));
            if (ins[20]) begin
               for (int i = 0; i < mw; i++) seq.push_back(mk(4'd3, 1'b0, 4'($urandom), 4'b0000, 3'd0, 1'b0));
               seq.push_back(mk(4'd3, 1'b1, 4'($urandom), 4'b0000, 3'd0, 1'b0));
               seq.push_back(mk(4'd4, 1'($urandom), 4'($urandom), {3'b000, ce}, 3'd0, 1'b0));
            end else begin
               for (int i = 0; i < mw; i++) seq.push_back(mk(4'd5, 1'b0, 4'($urandom), {2'b00, ce, 1'b0}, 3'd0, 1'b0));
               seq.push_back(mk(4'd5, 1'b1, 4'($urandom), {2'b00, ce, 1'b0}, 3'd0, 1'b0));
            end
         end
         2'b10: seq.push_back(mk(4'd9, 1'($urandom), 4'($urandom), {ce, 3'b000}, 3'd0, 1'b0));
         2'b11: ;
         default: begin
            is_mul = (ins[7:4] == 4'b1001);
`ifdef ARM_MC_MUL_EN
            if (is_mul) begin
               af = 4'd0;
               for (int k = 0; k < int'(MulLat); k++) begin
                  af = 4'($urandom);
                  seq.push_back(mk(4'd10, 1'($urandom), af, 4'b0000, 3'b100, 1'b1));
               end
               if (ins[20] && ce) mflags[3:2] = af[3:2];
               ce2 = cond_holds(ins[31:28], mflags);
               seq.push_back(mk(4'd8, 1'($urandom), 4'($urandom), {3'b000, ce2}, 3'd0, 1'b0));
               return;
            end
`endif
            case (ins[24:21])
               4'b0100: begin aluc = 3'b000; writes = 1'b1; kind = 2'd1; end
               4'b0010: begin aluc = 3'b001; writes = 1'b1; kind = 2'd1; end
               4'b0000: begin aluc = 3'b010; writes = 1'b1; kind = 2'd2; end
               4'b1100: begin aluc = 3'b011; writes = 1'b1; kind = 2'd2; end
               4'b1010: begin aluc = 3'b001; writes = 1'b0; kind = 2'd1; end
               default: begin aluc = 3'b000; writes = 1'b0; kind = 2'd0; end
            endcase
            if (is_mul) begin writes = 1'b0; kind = 2'd0; end
            st = (ins[25] && !is_mul) ? 4'd7 : 4'd6;
            af = 4'($urandom);
            seq.push_back(mk(st, 1'($urandom), af, 4'b0000, aluc, !is_mul));
            if (ins[20] && ce) begin
               if (kind == 2'd1) mflags = af;
               else if (kind == 2'd2) mflags[3:2] = af[3:2];
            end
            ce2 = cond_holds(ins[31:28], mflags);
            seq.push_back(mk(4'd8, 1'($urandom), 4'($urandom), {3'b000, ce2 && writes}, 3'd0, 1'b0));
         end
      endcase
   endtask

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      logic [3:0]  cmds [6];
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0111};
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[31:28] = 4'b1110;
      case ($urandom_range(0, 9))
         0, 1, 2, 3: begin
            r[27:26] = 2'b00;
            r[24:21] = cmds[$urandom_range(0, 5)];
            if (r[7:4] == 4'b1001) r[7] = 1'b0;
         end
         4:       begin r[27:26] = 2'b00; r[7:4] = 4'b1001; end
         5, 6:    r[27:26] = 2'b01;
         7, 8:    r[27:26] = 2'b10;
         default: r[27:26] = 2'b11;
      endcase
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic apply_reset();
      reset    = 1'b0;
      MemReady = 1'b0;
      @(posedge clk);
      #1;
      reset  = 1'b1;
      mflags = 4'b0000;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; MemReady = 1'b1; Instr = 32'hE0921003; ALUFlags = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (State !== 4'd0) begin
            bad++; $display("FAIL reset_state cyc=%0d got=%0d exp=0", i, State);
         end
         total++;
         if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes cyc=%0d got=%b exp=0000", i,
                            {PCWrite, IRWrite, MemWrite, RegWrite});
         end
         total++;
         if ({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc} !== 6'b1_10_10_0) begin
            bad++; $display("FAIL reset_fetch_mux got=%b exp=110100", {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc});
         end
      end
      next_cycle();
      reset = 1'b1; mflags = 4'b0000;
      @(negedge clk);
      total++;
      if ({State, PCWrite, IRWrite} !== {4'd0, 2'b11}) begin
         bad++; $display("FAIL reset_release got state=%0d pcw=%b irw=%b exp state=0 pcw=1 irw=1",
                         State, PCWrite, IRWrite);
      end
      next_cycle();
   endtask

   task automatic test_adds();
      logic [3:0] exp_st [4];
      exp_st = '{4'd0, 4'd1, 4'd6, 4'd8};
      apply_reset();
      Instr = 32'hE0921003; ALUFlags = 4'b0100; MemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (State !== exp_st[i]) begin
            bad++; $display("FAIL adds_state cyc=%0d got=%0d exp=%0d", i, State, exp_st[i]);
         end
         total++;
         if (RegWrite !== (i == 3)) begin
            bad++; $display("FAIL adds_regwrite cyc=%0d got=%b exp=%b", i, RegWrite, (i == 3));
         end
         if (i == 2) begin
            total++;
            if (ALUControl !== 3'b000) begin
               bad++; $display("FAIL adds_aluctl got=%b exp=000", ALUControl);
            end
         end
         next_cycle();
      end
      // Z now set: BEQ must be taken
      Instr = 32'h0A000002; ALUFlags = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) begin
            total++;
            if ({State, PCWrite} !== {4'd9, 1'b1}) begin
               bad++; $display("FAIL adds_zflag got state=%0d pcw=%b exp state=9 pcw=1", State, PCWrite);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_ldr_wait();
      logic [3:0] exp_st [7];
      logic       mr     [7];
      exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
      mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      apply_reset();
      Instr = 32'hE5912000;
      for (int i = 0; i < 7; i++) begin
         MemReady = mr[i]; ALUFlags = 4'($urandom);
         @(negedge clk);
         total++;
         if (State !== exp_st[i]) begin
            bad++; $display("FAIL ldr_state cyc=%0d got=%0d exp=%0d", i, State, exp_st[i]);
         end
         total++;
         if (RegWrite !== (i == 6)) begin
            bad++; $display("FAIL ldr_regwrite cyc=%0d got=%b exp=%b", i, RegWrite, (i == 6));
         end
         if (exp_st[i] == 4'd3) begin
            total++;
            if (AdrSrc !== 1'b1) begin
               bad++; $display("FAIL ldr_adrsrc cyc=%0d got=%b exp=1", i, AdrSrc);
            end
         end
         next_cycle();
      end
      @(negedge clk);
      total++;
      if (State !== 4'd0) begin
         bad++; $display("FAIL ldr_return got=%0d exp=0", State);
      end
      next_cycle();
   endtask

   task automatic test_beq();
      logic [3:0] exp_st [3];
      exp_st = '{4'd0, 4'd1, 4'd9};
      apply_reset();
      MemReady = 1'b1; Instr = 32'h0A000002;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (State !== exp_st[i]) begin
            bad++; $display("FAIL beq_state cyc=%0d got=%0d exp=%0d", i, State, exp_st[i]);
         end
         total++;
         if (PCWrite !== (i == 0)) begin
            bad++; $display("FAIL beq_nottaken_pcw cyc=%0d got=%b exp=%b", i, PCWrite, (i == 0));
         end
         if (i == 2) begin
            total++;
            if (RegSrc[0] !== 1'b1) begin
               bad++; $display("FAIL beq_regsrc got=%b exp=1", RegSrc[0]);
            end
         end
         next_cycle();
      end
      // set Z with ADDS, then repeat the branch
      Instr = 32'hE0921003; ALUFlags = 4'b0100;
      repeat (4) next_cycle();
      Instr = 32'h0A000002; ALUFlags = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 2) begin
            total++;
            if ({State, PCWrite} !== {4'd9, 1'b1}) begin
               bad++; $display("FAIL beq_taken got state=%0d pcw=%b exp state=9 pcw=1", State, PCWrite);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_mul();
      logic [3:0] exp_st[$];
      logic       exp_rw;
      exp_st.push_back(4'd0);
      exp_st.push_back(4'd1);
`ifdef ARM_MC_MUL_EN
      for (int k = 0; k < int'(MulLat); k++) exp_st.push_back(4'd10);
      exp_rw = 1'b1;
`else
      exp_st.push_back(4'd6);
      exp_rw = 1'b0;
`endif
      exp_st.push_back(4'd8);
      apply_reset();
      MemReady = 1'b1; Instr = 32'hE0000291;
      foreach (exp_st[i]) begin
         ALUFlags = 4'($urandom);
         @(negedge clk);
         total++;
         if (State !== exp_st[i]) begin
            bad++; $display("FAIL mul_state cyc=%0d got=%0d exp=%0d", i, State, exp_st[i]);
         end
         if (exp_st[i] == 4'd10) begin
            total++;
            if (ALUControl !== 3'b100) begin
               bad++; $display("FAIL mul_aluctl cyc=%0d got=%b exp=100", i, ALUControl);
            end
         end
         if (exp_st[i] == 4'd8) begin
            total++;
            if (RegWrite !== exp_rw) begin
               bad++; $display("FAIL mul_regwrite got=%b exp=%b", RegWrite, exp_rw);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_midwrite();
      apply_reset();
      Instr = 32'hE5812000; MemReady = 1'b1;
      repeat (3) next_cycle();
      MemReady = 1'b0;
      @(negedge clk);
      total++;
      if ({State, MemWrite} !== {4'd5, 1'b1}) begin
         bad++; $display("FAIL midwr_before got state=%0d mw=%b exp state=5 mw=1", State, MemWrite);
      end
      reset = 1'b0;
      #1;
      total++;
      if ({State, MemWrite, PCWrite, RegWrite} !== {4'd0, 3'b000}) begin
         bad++; $display("FAIL midwr_reset got state=%0d mw=%b pcw=%b rw=%b exp state=0 strobes 0",
                         State, MemWrite, PCWrite, RegWrite);
      end
      next_cycle();
      reset = 1'b1; mflags = 4'b0000;
      @(negedge clk);
      total++;
      if ({State, MemWrite} !== {4'd0, 1'b0}) begin
         bad++; $display("FAIL midwr_release got state=%0d mw=%b exp state=0 mw=0", State, MemWrite);
      end
      next_cycle();
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic        desync;
      apply_reset();
      for (int n = 0; n < 250; n++) begin
         ins = gen_instr();
         seq.delete();
         build_seq(ins, $urandom_range(0, 2), $urandom_range(0, 2));
         Instr  = ins;
         desync = 1'b0;
         foreach (seq[i]) begin
            MemReady = seq[i].mr; ALUFlags = seq[i].af;
            @(negedge clk);
            total++;
            if (State !== seq[i].st) begin
               bad++; desync = 1'b1;
               $display("FAIL rand_state n=%0d cyc=%0d ins=%h got=%0d exp=%0d", n, i, ins, State, seq[i].st);
            end
            total++;
            if ({PCWrite, IRWrite, MemWrite, RegWrite} !== seq[i].wr) begin
               bad++;
               $display("FAIL rand_strobes n=%0d cyc=%0d ins=%h got=%b exp=%b", n, i, ins,
                        {PCWrite, IRWrite, MemWrite, RegWrite}, seq[i].wr);
            end
            if (seq[i].ck_alu) begin
               total++;
               if (ALUControl !== seq[i].aluc) begin
                  bad++;
                  $display("FAIL rand_aluctl n=%0d ins=%h got=%b exp=%b", n, ins, ALUControl, seq[i].aluc);
               end
            end
            total++;
            if (ImmSrc !== ins[27:26]) begin
               bad++; $display("FAIL rand_immsrc n=%0d got=%b exp=%b", n, ImmSrc, ins[27:26]);
            end
            next_cycle();
            if (desync) break;
         end
         if (desync) apply_reset();
      end
   endtask

   initial begin
      reset = 1'b0; Instr = 32'd0; ALUFlags = 4'd0; MemReady = 1'b1; mflags = 4'd0;
      test_reset();
      test_adds();
      test_ldr_wait();
      test_beq();
      test_mul();
      test_reset_midwrite();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the ARM subset core: decodes `Instr`, sequences each instruction through a main FSM, holds the NZCV flag register and gates architectural writes on the condition field. It replaces the single-cycle controller. Memory accesses use a ready handshake, so instruction and data memories may insert wait states. Multiply executes over a parametrised number of cycles.

## Interface
- `MUL_LAT`, 1, cycles spent in EXECMUL (legal 1..15).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `Instr`  in  32  instruction register contents.
- `ALUFlags`  in  4  {N,Z,C,V} from the datapath ALU, current cycle.
- `MemReady`  in  1  memory completes the current access this cycle.
- `PCWrite`  out  1  PC load enable.
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  data-memory write strobe.
- `IRWrite`  out  1  instruction-register load.
- `RegWrite`  out  1  register-file write.
- `ResultSrc`  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- `ALUSrcA`  out  1  0 = A register, 1 = PC.
- `ALUSrcB`  out  2  00 WriteData register, 01 ExtImm, 10 constant 4.
- `ImmSrc`  out  2  equal to `Instr[27:26]`.
- `RegSrc`  out  2  bit0 = read R15 (branch), bit1 = read Rd as source 2 (store).
- `ALUControl`  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL.
- `State`  out  4  current FSM state (debug).

## Operation
- States, with encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, EXECMUL 10.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD (computes PC+8).
  - Op=01: go to MEMADR.
  - Op=10: go to BRANCH.
  - Op=00 and `Instr[7:4]`=1001 (macro on): go to EXECMUL.
  - Op=00, I=1: go to EXECUTEI.
  - Op=00, I=0: go to EXECUTER.
  - Op=11: go to FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. L=1 goes to MEMREAD; L=0 goes to MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=CondEx for every cycle in the state. Holds until MemReady, then goes to FETCH.
- EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 / 01. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx & writes. Goes to FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, RegSrc[0]=1, PCWrite=CondEx. Goes to FETCH.
- EXECMUL: ALUControl=100. Down-counter loaded with MUL_LAT-1 on entry; leaves for ALUWB when the counter reads 0.
- cmd decode (`Instr[24:21]`):
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR: writes=1.
  - 1010 CMP: SUB, writes=0.
  - Any other cmd: ADD, writes=0, no flag update.
- CondEx: standard ARM cond over the stored flags (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL). cond 1111 evaluates false.
- Flag update: at the final execute cycle, if S=1 and CondEx=1.
  - ADD/SUB/CMP: NZCV ← ALUFlags.
  - AND/ORR/MUL: only N and Z are updated.

## Timing
- Cycle counts with zero wait states:
  - DP register/immediate: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - MUL: 3+MUL_LAT cycles.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- All outputs are combinational from State, Instr, flags and MemReady.
- Flags and State are registered.
- Flags written in the final execute cycle are visible to CondEx from the next cycle on.
- While reset=0:
  - State=FETCH, flags=0000, multiply counter=0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Other outputs show FETCH values.
- Reset deasserted mid-instruction: the FSM restarts in FETCH and no partial write occurs.
- MemReady arriving in a non-memory state is ignored.

## Configuration
- `ARM_MC_MUL_EN` defined: MUL is decoded, EXECMUL exists, and ALUControl can take the value 100.
- `ARM_MC_MUL_EN` undefined: an Op=00 instruction with `Instr[7:4]`=1001 follows the EXECUTER path with writes=0 and no flag update. EXECMUL and its counter are not built, and MUL_LAT is ignored.

## Test plan
- Reset: hold reset=0 for 3 cycles with MemReady=1 → State=0, PCWrite=IRWrite=MemWrite=RegWrite=0. Release → PCWrite=IRWrite=1 on the first cycle.
- ADDS R1,R2,R3 (0xE0921003), ALUFlags=0100 at EXECUTER → states 0,1,6,8. RegWrite=1 in ALUWB. Z flag set afterwards.
- LDR with MemReady=0 for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4. Total 7 cycles, RegWrite only in MEMWB.
- BEQ with Z=0 (0x0A000002) → states 0,1,9, with PCWrite=0 in BRANCH. Repeat after setting Z → PCWrite=1.
- MUL R0,R1,R2 (0xE0000291), MUL_LAT=3, macro on → EXECMUL for 3 cycles with ALUControl=100, then ALUWB. With the macro off → states 0,1,6,8 and RegWrite=0.
- Reset asserted during MEMWRITE with MemReady=0 → MemWrite drops immediately. After release → State=FETCH.
